// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results through, and runs loads/stores over a
// ready/valid data-memory port with lane alignment, store masking and load extension.
package rvga_pkg;
   localparam int RVGA_WORD_W = 32;
   typedef logic [RVGA_WORD_W-1:0] rvga_word;

   typedef struct packed {
      logic       v;
      logic       mem_rd;
      logic       mem_wr;
      logic [2:0] funct3;
      rvga_word   alu_result;
      rvga_word   rs2_data;
      logic [4:0] rd_addr;
      logic       rd_w_v;
   } rvga_execute_cword;

   typedef struct packed {
      logic       v;
      logic [4:0] rd_addr;
      logic       rd_w_v;
      rvga_word   rd_data;
      logic       misaligned;
   } rvga_memory_cword;
endpackage

module memory_stage
   import rvga_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_v_i,
   input  rvga_execute_cword cword_i,
   output rvga_memory_cword  cword_o,
   output logic              stall_v_o,
   output logic              dmem_req_v_o,
   output logic              dmem_req_we_o,
   output logic [31:0]       dmem_req_addr_o,
   output logic [31:0]       dmem_req_wdata_o,
   output logic [3:0]        dmem_req_wmask_o,
   input  logic              dmem_req_ready_i,
   input  logic              dmem_resp_v_i,
   input  logic [31:0]       dmem_resp_rdata_i
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       r_state;
   rvga_memory_cword r_cword;
   rvga_memory_cword r_hold;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wmask;
   logic             r_we;
   logic [2:0]       r_funct3;
   logic [1:0]       r_off;

   logic             w_mem_op;
   logic             w_is_store;
   logic             w_misaligned;
   logic [1:0]       w_off;
   logic [31:0]      w_wdata;
   logic [3:0]       w_wmask;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load_data;

   // Both mem_rd and mem_wr set is handled as a load.
   always_comb begin
      w_off        = cword_i.alu_result[1:0];
      w_mem_op     = cword_i.mem_rd | cword_i.mem_wr;
      w_is_store   = cword_i.mem_wr & ~cword_i.mem_rd;
      w_misaligned = 1'b0;
      w_wdata      = cword_i.rs2_data;
      w_wmask      = 4'b1111;
      case (cword_i.funct3[1:0])
         2'b00: begin
            w_wdata = {4{cword_i.rs2_data[7:0]}};
            w_wmask = 4'b0001 << w_off;
         end
         2'b01: begin
            w_misaligned = w_off[0];
            w_wdata      = {2{cword_i.rs2_data[15:0]}};
            w_wmask      = 4'b0011 << {w_off[1], 1'b0};
         end
         default: begin
            w_misaligned = |w_off;
         end
      endcase
      if (!w_is_store) begin
         w_wmask = 4'b0000;
      end
   end

   always_comb begin
      case (r_off)
         2'd0:    w_byte = dmem_resp_rdata_i[7:0];
         2'd1:    w_byte = dmem_resp_rdata_i[15:8];
         2'd2:    w_byte = dmem_resp_rdata_i[23:16];
         default: w_byte = dmem_resp_rdata_i[31:24];
      endcase
      w_half = r_off[1] ? dmem_resp_rdata_i[31:16] : dmem_resp_rdata_i[15:0];
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_data = {24'd0, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_data = {16'd0, w_half};
         default: w_load_data = dmem_resp_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_cword  <= '0;
         r_hold   <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wmask  <= '0;
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_off    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!stall_v_i) begin
                  if (!cword_i.v) begin
                     r_cword.v <= 1'b0;
                  end else if (!w_mem_op) begin
                     r_cword <= '{v: 1'b1, rd_addr: cword_i.rd_addr, rd_w_v: cword_i.rd_w_v,
                                  rd_data: cword_i.alu_result, misaligned: 1'b0};
                  end else if (w_misaligned) begin
                     r_cword <= '{v: 1'b1, rd_addr: cword_i.rd_addr, rd_w_v: 1'b0,
                                  rd_data: 32'd0, misaligned: 1'b1};
                  end else begin
                     r_hold   <= '{v: 1'b1, rd_addr: cword_i.rd_addr,
                                   rd_w_v: cword_i.rd_w_v & ~w_is_store,
                                   rd_data: 32'd0, misaligned: 1'b0};
                     r_addr   <= {cword_i.alu_result[31:2], 2'b00};
                     r_wdata  <= w_wdata;
                     r_wmask  <= w_wmask;
                     r_we     <= w_is_store;
                     r_funct3 <= cword_i.funct3;
                     r_off    <= w_off;
                     r_cword.v <= 1'b0;
                     r_state  <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_req_ready_i) begin
                  r_state <= r_we ? ST_DONE : ST_RESP;
               end
            end
            ST_RESP: begin
               if (dmem_resp_v_i) begin
                  r_hold.rd_data <= w_load_data;
                  r_state        <= ST_DONE;
               end
            end
            default: begin
               if (!stall_v_i) begin
                  r_cword <= r_hold;
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign cword_o          = r_cword;
   assign stall_v_o        = stall_v_i | (r_state != ST_IDLE);
   assign dmem_req_v_o     = (r_state == ST_REQ);
   assign dmem_req_we_o    = r_we;
   assign dmem_req_addr_o  = r_addr;
   assign dmem_req_wdata_o = r_wdata;
   assign dmem_req_wmask_o = (r_state == ST_REQ) ? r_wmask : 4'b0000;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases followed by randomized loads/stores/ALU ops
// checked against a byte-level reference model.
module tb_memory_stage;
   import rvga_pkg::*;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              stall_v_i;
   rvga_execute_cword cword_i;
   rvga_memory_cword  cword_o;
   logic              stall_v_o;
   logic              dmem_req_v_o;
   logic              dmem_req_we_o;
   logic [31:0]       dmem_req_addr_o;
   logic [31:0]       dmem_req_wdata_o;
   logic [3:0]        dmem_req_wmask_o;
   logic              dmem_req_ready_i;
   logic              dmem_resp_v_i;
   logic [31:0]       dmem_resp_rdata_i;

   int n_vec  = 0;
   int n_miss = 0;

   memory_stage dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .stall_v_i         (stall_v_i),
      .cword_i           (cword_i),
      .cword_o           (cword_o),
      .stall_v_o         (stall_v_o),
      .dmem_req_v_o      (dmem_req_v_o),
      .dmem_req_we_o     (dmem_req_we_o),
      .dmem_req_addr_o   (dmem_req_addr_o),
      .dmem_req_wdata_o  (dmem_req_wdata_o),
      .dmem_req_wmask_o  (dmem_req_wmask_o),
      .dmem_req_ready_i  (dmem_req_ready_i),
      .dmem_resp_v_i     (dmem_resp_v_i),
      .dmem_resp_rdata_i (dmem_resp_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference model: access size in bytes and byte-level lane arithmetic.
   function automatic int sz(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit misal(input logic [2:0] f3, input logic [31:0] a);
      return (a % sz(f3)) != 0;
   endfunction

   function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] rs2);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = rs2[8*(i % sz(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [3:0] st_mask(input logic [2:0] f3, input logic [31:0] a);
      int m;
      m = ((1 << sz(f3)) - 1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] ld_data(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
      logic [63:0] v;
      int n;
      n = 8 * sz(f3);
      v = {32'd0, rd} >> (8 * (a % 4));
      v = v & ((64'd1 << n) - 64'd1);
      if (!f3[2] && n < 32 && v[n-1]) v = v - (64'd1 << n);
      return v[31:0];
   endfunction

   function automatic rvga_execute_cword mk(input logic v, input logic rd, input logic wr,
                                            input logic [2:0] f3, input logic [31:0] alu,
                                            input logic [31:0] rs2, input logic [4:0] ra,
                                            input logic rw);
      rvga_execute_cword c;
      c.v = v; c.mem_rd = rd; c.mem_wr = wr; c.funct3 = f3; c.alu_result = alu;
      c.rs2_data = rs2; c.rd_addr = ra; c.rd_w_v = rw;
      return c;
   endfunction

   // Entry and exit at #1 after a rising edge.
   task automatic mem_op(input rvga_execute_cword ex, input int rdly, input int sdly,
                         input logic [31:0] rdata, input string tag);
      bit st;
      int cyc;
      int exp_lat;
      st      = ex.mem_wr && !ex.mem_rd;
      exp_lat = st ? 3 + rdly : 4 + rdly + sdly;
      cword_i = ex;
      @(posedge clk); #1;
      cword_i.v = 1'b0;
      cyc = 1;
      for (int k = 0; k <= rdly; k++) begin
         dmem_req_ready_i  = (k == rdly);
         dmem_resp_v_i     = 1'($urandom_range(0, 1));
         dmem_resp_rdata_i = $urandom;
         @(negedge clk);
         chk({tag, " req_v"}, dmem_req_v_o, 1);
         chk({tag, " we"}, dmem_req_we_o, st);
         chk({tag, " addr"}, dmem_req_addr_o, ex.alu_result & 32'hFFFF_FFFC);
         chk({tag, " wmask"}, dmem_req_wmask_o, st ? st_mask(ex.funct3, ex.alu_result) : 4'd0);
         if (st) chk({tag, " wdata"}, dmem_req_wdata_o, st_data(ex.funct3, ex.rs2_data));
         chk({tag, " stall_o"}, stall_v_o, 1);
         @(posedge clk); #1;
         cyc++;
      end
      dmem_req_ready_i = 1'b0;
      dmem_resp_v_i    = 1'b0;
      if (!st) begin
         for (int k = 0; k <= sdly; k++) begin
            dmem_resp_v_i     = (k == sdly);
            dmem_resp_rdata_i = (k == sdly) ? rdata : $urandom;
            @(posedge clk); #1;
            cyc++;
         end
         dmem_resp_v_i = 1'b0;
      end
      while (cword_o.v !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, " latency"}, cyc, exp_lat);
      chk({tag, " out_v"}, cword_o.v, 1);
      chk({tag, " rd_w_v"}, cword_o.rd_w_v, st ? 1'b0 : ex.rd_w_v);
      chk({tag, " rd_addr"}, cword_o.rd_addr, ex.rd_addr);
      chk({tag, " misal"}, cword_o.misaligned, 0);
      if (!st) chk({tag, " rd_data"}, cword_o.rd_data, ld_data(ex.funct3, ex.alu_result, rdata));
   endtask

   task automatic misal_op(input rvga_execute_cword ex, input string tag);
      cword_i = ex;
      @(posedge clk); #1;
      cword_i.v = 1'b0;
      chk({tag, " v"}, cword_o.v, 1);
      chk({tag, " misal"}, cword_o.misaligned, 1);
      chk({tag, " rd_w_v"}, cword_o.rd_w_v, 0);
      chk({tag, " req_v"}, dmem_req_v_o, 0);
      chk({tag, " stall_o"}, stall_v_o, 0);
   endtask

   task automatic alu_op(input logic [31:0] val, input logic [4:0] ra, input string tag);
      cword_i = mk(1, 0, 0, 3'b000, val, $urandom, ra, 1);
      @(posedge clk); #1;
      cword_i.v = 1'b0;
      chk({tag, " v"}, cword_o.v, 1);
      chk({tag, " rd_data"}, cword_o.rd_data, val);
      chk({tag, " rd_addr"}, cword_o.rd_addr, ra);
      chk({tag, " misal"}, cword_o.misaligned, 0);
   endtask

   initial begin
      logic [31:0] ld_word;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] rd;
      logic [2:0]  ld_f3 [5];
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      ld_word = 32'h80FF7F01;

      // Reset with every input active except stall.
      rst_i = 1'b1; stall_v_i = 1'b0;
      cword_i = mk(1, 1, 0, 3'b010, 32'h40, 32'h1234, 5'd3, 1);
      dmem_req_ready_i = 1'b1; dmem_resp_v_i = 1'b1; dmem_resp_rdata_i = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst out_v", cword_o.v, 0);
      chk("rst req_v", dmem_req_v_o, 0);
      chk("rst stall_o", stall_v_o, 0);
      chk("rst wmask", dmem_req_wmask_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0; cword_i.v = 1'b0;
      dmem_req_ready_i = 1'b0; dmem_resp_v_i = 1'b0;

      // Back-to-back ALU ops on consecutive cycles.
      for (int i = 1; i <= 3; i++) begin
         cword_i = mk(1, 0, 0, 3'b000, i, 32'd0, 5'(i), 1);
         @(posedge clk); #1;
         chk($sformatf("b2b%0d rd_data", i), cword_o.rd_data, i);
         chk($sformatf("b2b%0d v", i), cword_o.v, 1);
      end
      cword_i.v = 1'b0;
      @(posedge clk); #1;
      chk("idle v", cword_o.v, 0);

      // Downstream stall in IDLE holds the previous output.
      alu_op(32'h3, 5'd9, "pre_stall");
      stall_v_i = 1'b1;
      cword_i = mk(1, 0, 0, 3'b000, 32'h7, 32'd0, 5'd10, 1);
      @(posedge clk); #1;
      chk("stall hold data", cword_o.rd_data, 32'h3);
      chk("stall hold v", cword_o.v, 1);
      chk("stall stall_o", stall_v_o, 1);
      stall_v_i = 1'b0;
      @(posedge clk); #1;
      cword_i.v = 1'b0;
      chk("unstall data", cword_o.rd_data, 32'h7);

      // Directed store and loads.
      mem_op(mk(1, 0, 1, 3'b000, 32'h102, 32'h000000A5, 5'd4, 1), 2, 0, 32'd0, "SB");
      mem_op(mk(1, 1, 0, 3'b000, 32'h3, 32'd0, 5'd5, 1), 0, 0, ld_word, "LB");
      mem_op(mk(1, 1, 0, 3'b100, 32'h3, 32'd0, 5'd6, 1), 1, 1, ld_word, "LBU");
      mem_op(mk(1, 1, 0, 3'b001, 32'h2, 32'd0, 5'd7, 1), 0, 2, ld_word, "LH");
      mem_op(mk(1, 1, 0, 3'b101, 32'h0, 32'd0, 5'd8, 1), 2, 0, ld_word, "LHU");
      mem_op(mk(1, 1, 0, 3'b010, 32'h0, 32'd0, 5'd9, 1), 0, 0, ld_word, "LW");
      chk("LW const", cword_o.rd_data, 32'h80FF7F01);
      misal_op(mk(1, 1, 0, 3'b010, 32'h2, 32'd0, 5'd1, 1), "LW misal");
      misal_op(mk(1, 1, 0, 3'b001, 32'h1, 32'd0, 5'd2, 1), "LH misal");

      // Downstream stall arriving with the response, held three cycles.
      cword_i = mk(1, 1, 0, 3'b010, 32'h10, 32'd0, 5'd11, 1);
      @(posedge clk); #1;
      cword_i.v = 1'b0; dmem_req_ready_i = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready_i = 1'b0;
      dmem_resp_v_i = 1'b1; dmem_resp_rdata_i = 32'hCAFE_F00D; stall_v_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rstall%0d stall_o", i), stall_v_o, 1);
         @(posedge clk); #1;
         dmem_resp_v_i = 1'b0; dmem_resp_rdata_i = $urandom;
         chk($sformatf("rstall%0d v", i), cword_o.v, 0);
      end
      stall_v_i = 1'b0;
      @(posedge clk); #1;
      chk("rstall out v", cword_o.v, 1);
      chk("rstall rd_data", cword_o.rd_data, 32'hCAFE_F00D);

      // Reset while waiting for the response abandons the access.
      cword_i = mk(1, 1, 0, 3'b010, 32'h20, 32'd0, 5'd12, 1);
      @(posedge clk); #1;
      cword_i.v = 1'b0; dmem_req_ready_i = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready_i = 1'b0; rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      chk("rstresp req_v", dmem_req_v_o, 0);
      chk("rstresp stall_o", stall_v_o, 0);
      dmem_resp_v_i = 1'b1; dmem_resp_rdata_i = 32'h1111_2222;
      @(posedge clk); #1;
      dmem_resp_v_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rstresp%0d v", i), cword_o.v, 0);
         chk($sformatf("rstresp%0d stall_o", i), stall_v_o, 0);
         @(posedge clk); #1;
      end

      // Randomized mix.
      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         a = $urandom;
         rd = $urandom;
         if (kind == 0) begin
            alu_op(a, 5'($urandom), $sformatf("r%0d alu", i));
         end else if (kind == 1) begin
            f3 = 3'($urandom_range(0, 2));
            if (misal(f3, a))
               misal_op(mk(1, 0, 1, f3, a, rd, 5'($urandom), 1), $sformatf("r%0d st_mis", i));
            else
               mem_op(mk(1, 0, 1, f3, a, rd, 5'($urandom), 1'($urandom)),
                      $urandom_range(0, 3), 0, 32'd0, $sformatf("r%0d st f%0d", i, f3));
         end else begin
            f3 = ld_f3[$urandom_range(0, 4)];
            if (misal(f3, a))
               misal_op(mk(1, 1, 1'($urandom), f3, a, 32'd0, 5'($urandom), 1),
                        $sformatf("r%0d ld_mis", i));
            else
               mem_op(mk(1, 1, ($urandom_range(0, 7) == 0), f3, a, $urandom, 5'($urandom),
                         1'($urandom)),
                      $urandom_range(0, 3), $urandom_range(0, 3), rd,
                      $sformatf("r%0d ld f%0d", i, f3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
